// File: rtl/fir_tap_mac_reader.sv
// fir_tap_mac_reader: consumer end of the FIR tapped delay line.
// Snapshots N taps/coefficients on an input handshake, accumulates the dot
// product through one shared signed 16x16 multiplier (one product per cycle)
// and presents the result on a valid/ready output handshake.
// Optional build macro: FIR_ROUND_SAT_EN -- when defined, y_out is the Q30
// accumulator rounded (half up) to Q15 and saturated to 16 bits, then
// sign-extended; when undefined, y_out is the raw full-precision accumulator.
module fir_tap_mac_reader #(
  parameter int N     = 8,
  parameter int ACC_W = 32 + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [15:0]      taps_in [0:N-1],
  input  logic signed [15:0]      coef_in [0:N-1],
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] y_out,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [15:0]      snap_tap  [0:N-1];
  logic signed [15:0]      snap_coef [0:N-1];
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        idx;
  logic signed [31:0]      prod;
  logic                    last;

  // One shared multiplier reads the snapshot entry selected by idx.
  assign prod = snap_tap[idx] * snap_coef[idx];
  assign last = (idx == IDX_LAST);

  // State register; reset always wins over any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: accept in IDLE, N MAC cycles, hold in OUT until taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = MAC;
        end else begin
          state_next = IDLE;
        end
      end
      MAC: begin
        if (last) begin
          state_next = OUT;
        end else begin
          state_next = MAC;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = OUT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      MAC:     in_ready  = 1'b0;
      OUT:     out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: snapshot on accept, then one multiply-accumulate per MAC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
      for (int i = 0; i < N; i++) begin
        snap_tap[i]  <= 16'sd0;
        snap_coef[i] <= 16'sd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) begin
              snap_tap[i]  <= taps_in[i];
              snap_coef[i] <= coef_in[i];
            end
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (last) begin
            idx <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          acc <= acc;
          idx <= idx;
        end
      endcase
    end
  end

`ifdef FIR_ROUND_SAT_EN
  localparam logic signed [ACC_W:0] HALF_LSB = (ACC_W+1)'(16384);
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] SAT_MIN  = -(ACC_W+1)'(32768);

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] rnd;

  // Round Q30 to Q15 (half up), saturate to 16 bits, sign-extend.
  always_comb begin
    acc_ext = {acc[ACC_W-1], acc};
    rnd     = (acc_ext + HALF_LSB) >>> 15;
    if (rnd > SAT_MAX) begin
      y_out = {{(ACC_W-16){1'b0}}, 16'h7FFF};
    end else if (rnd < SAT_MIN) begin
      y_out = {{(ACC_W-16){1'b1}}, 16'h8000};
    end else begin
      y_out = {{(ACC_W-16){rnd[15]}}, rnd[15:0]};
    end
  end
`else
  // Raw build: result is the registered full-precision accumulator.
  always_comb begin
    y_out = acc;
  end
`endif

endmodule
